// File: rtl/branch_rs.sv
// rtl/branch_rs.sv - branch reservation station: CDB wake-up, oldest-ready issue to the branch FU
// Optional macro BRANCH_RS_OLDEST_FIRST_EN: age-matrix select; undefined gives fixed lowest-index priority.
module branch_rs #(
    parameter int RS_ENTRIES   = 4,
    parameter int WORD_SIZE_P  = 16,
    parameter int WIDTH_OP     = 4,
    parameter int ROB_ENTRY    = 16,
    parameter int NUM_PHYS_REG = 32
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              flush_i,
    input  logic                              disp_v_i,
    output logic                              disp_ready_o,
    input  logic [WIDTH_OP-1:0]               disp_opcode_i,
    input  logic [WORD_SIZE_P-1:0]            disp_pc_i,
    input  logic                              disp_src1_rdy_i,
    input  logic                              disp_src2_rdy_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0]   disp_src1_tag_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0]   disp_src2_tag_i,
    input  logic [WORD_SIZE_P-1:0]            disp_src1_val_i,
    input  logic [WORD_SIZE_P-1:0]            disp_src2_val_i,
    input  logic [$clog2(ROB_ENTRY)-1:0]      disp_rob_dest_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0]   disp_reg_dest_i,
    input  logic                              cdb_v_i,
    input  logic [$clog2(NUM_PHYS_REG)-1:0]   cdb_dest_i,
    input  logic [WORD_SIZE_P-1:0]            cdb_result_i,
    output logic                              exe_v_o,
    output logic [WIDTH_OP-1:0]               opcode_o,
    output logic [WORD_SIZE_P-1:0]            pc_o,
    output logic [WORD_SIZE_P-1:0]            operand1_o,
    output logic [WORD_SIZE_P-1:0]            operand2_o,
    output logic [$clog2(ROB_ENTRY)-1:0]      rob_dest_o,
    output logic [$clog2(NUM_PHYS_REG)-1:0]   reg_dest_o,
    output logic [$clog2(RS_ENTRIES):0]       count_o
);
    localparam int RB = $clog2(ROB_ENTRY);
    localparam int PB = $clog2(NUM_PHYS_REG);
    localparam int IB = $clog2(RS_ENTRIES);
    localparam int CB = IB + 1;

    logic [RS_ENTRIES-1:0]  valid_q, valid_d;
    logic [RS_ENTRIES-1:0]  s1_rdy_q, s1_rdy_d, s2_rdy_q, s2_rdy_d;
    logic [WIDTH_OP-1:0]    op_q [RS_ENTRIES];
    logic [WIDTH_OP-1:0]    op_d [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] pc_q [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] pc_d [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] s1_val_q [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] s1_val_d [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] s2_val_q [RS_ENTRIES];
    logic [WORD_SIZE_P-1:0] s2_val_d [RS_ENTRIES];
    logic [PB-1:0]          s1_tag_q [RS_ENTRIES];
    logic [PB-1:0]          s1_tag_d [RS_ENTRIES];
    logic [PB-1:0]          s2_tag_q [RS_ENTRIES];
    logic [PB-1:0]          s2_tag_d [RS_ENTRIES];
    logic [RB-1:0]          rob_q [RS_ENTRIES];
    logic [RB-1:0]          rob_d [RS_ENTRIES];
    logic [PB-1:0]          rd_q [RS_ENTRIES];
    logic [PB-1:0]          rd_d [RS_ENTRIES];
`ifdef BRANCH_RS_OLDEST_FIRST_EN
    // age_q[j][i] set means entry j was dispatched before entry i
    logic [RS_ENTRIES-1:0]  age_q [RS_ENTRIES];
    logic [RS_ENTRIES-1:0]  age_d [RS_ENTRIES];
    logic                   older_ready;
`endif

    logic [CB-1:0]          count_q, count_d;
    logic                   exe_v_q, exe_v_d;
    logic [WIDTH_OP-1:0]    opcode_q, opcode_d;
    logic [WORD_SIZE_P-1:0] pc_out_q, pc_out_d, opnd1_q, opnd1_d, opnd2_q, opnd2_d;
    logic [RB-1:0]          rob_out_q, rob_out_d;
    logic [PB-1:0]          rd_out_q, rd_out_d;

    logic [RS_ENTRIES-1:0]  ready_vec;
    logic                   alloc_found, sel_found, disp_fire;
    logic [IB-1:0]          alloc_idx, sel_idx;

    assign disp_ready_o = (count_q < CB'(RS_ENTRIES));
    assign disp_fire    = disp_v_i && disp_ready_o;
    assign ready_vec    = valid_q & s1_rdy_q & s2_rdy_q;

    always_comb begin
        alloc_found = 1'b0;
        alloc_idx   = '0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_found = 1'b1;
                alloc_idx   = IB'(i);
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
`ifdef BRANCH_RS_OLDEST_FIRST_EN
        older_ready = 1'b0;
        for (int i = 0; i < RS_ENTRIES; i++) begin
            older_ready = 1'b0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (j != i && ready_vec[j] && age_q[j][i]) older_ready = 1'b1;
            end
            if (ready_vec[i] && !older_ready && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IB'(i);
            end
        end
`else
        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (ready_vec[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_idx   = IB'(i);
            end
        end
`endif
    end

    always_comb begin
        valid_d  = valid_q;
        s1_rdy_d = s1_rdy_q;
        s2_rdy_d = s2_rdy_q;
        op_d     = op_q;
        pc_d     = pc_q;
        s1_val_d = s1_val_q;
        s2_val_d = s2_val_q;
        s1_tag_d = s1_tag_q;
        s2_tag_d = s2_tag_q;
        rob_d    = rob_q;
        rd_d     = rd_q;
`ifdef BRANCH_RS_OLDEST_FIRST_EN
        age_d    = age_q;
`endif
        count_d   = count_q + CB'(disp_fire) - CB'(sel_found);
        exe_v_d   = sel_found;
        opcode_d  = opcode_q;
        pc_out_d  = pc_out_q;
        opnd1_d   = opnd1_q;
        opnd2_d   = opnd2_q;
        rob_out_d = rob_out_q;
        rd_out_d  = rd_out_q;

        for (int i = 0; i < RS_ENTRIES; i++) begin
            if (valid_q[i] && cdb_v_i) begin
                if (!s1_rdy_q[i] && s1_tag_q[i] == cdb_dest_i) begin
                    s1_rdy_d[i] = 1'b1;
                    s1_val_d[i] = cdb_result_i;
                end
                if (!s2_rdy_q[i] && s2_tag_q[i] == cdb_dest_i) begin
                    s2_rdy_d[i] = 1'b1;
                    s2_val_d[i] = cdb_result_i;
                end
            end
        end

        if (sel_found) begin
            valid_d[sel_idx] = 1'b0;
            opcode_d         = op_q[sel_idx];
            pc_out_d         = pc_q[sel_idx];
            opnd1_d          = s1_val_q[sel_idx];
            opnd2_d          = s2_val_q[sel_idx];
            rob_out_d        = rob_q[sel_idx];
            rd_out_d         = rd_q[sel_idx];
        end

        // a not-ready operand whose producer is on the CDB right now is captured here
        if (disp_fire) begin
            valid_d[alloc_idx]  = 1'b1;
            op_d[alloc_idx]     = disp_opcode_i;
            pc_d[alloc_idx]     = disp_pc_i;
            s1_tag_d[alloc_idx] = disp_src1_tag_i;
            s2_tag_d[alloc_idx] = disp_src2_tag_i;
            rob_d[alloc_idx]    = disp_rob_dest_i;
            rd_d[alloc_idx]     = disp_reg_dest_i;
            if (disp_src1_rdy_i) begin
                s1_rdy_d[alloc_idx] = 1'b1;
                s1_val_d[alloc_idx] = disp_src1_val_i;
            end else begin
                s1_rdy_d[alloc_idx] = cdb_v_i && (cdb_dest_i == disp_src1_tag_i);
                s1_val_d[alloc_idx] = cdb_result_i;
            end
            if (disp_src2_rdy_i) begin
                s2_rdy_d[alloc_idx] = 1'b1;
                s2_val_d[alloc_idx] = disp_src2_val_i;
            end else begin
                s2_rdy_d[alloc_idx] = cdb_v_i && (cdb_dest_i == disp_src2_tag_i);
                s2_val_d[alloc_idx] = cdb_result_i;
            end
`ifdef BRANCH_RS_OLDEST_FIRST_EN
            age_d[alloc_idx] = '0;
            for (int j = 0; j < RS_ENTRIES; j++) begin
                if (IB'(j) != alloc_idx) age_d[j][alloc_idx] = 1'b1;
            end
`endif
        end

        if (flush_i) begin
            valid_d = '0;
            count_d = '0;
            exe_v_d = 1'b0;
            opcode_d  = opcode_q;
            pc_out_d  = pc_out_q;
            opnd1_d   = opnd1_q;
            opnd2_d   = opnd2_q;
            rob_out_d = rob_out_q;
            rd_out_d  = rd_out_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q   <= '0;
            s1_rdy_q  <= '0;
            s2_rdy_q  <= '0;
            count_q   <= '0;
            exe_v_q   <= 1'b0;
            opcode_q  <= '0;
            pc_out_q  <= '0;
            opnd1_q   <= '0;
            opnd2_q   <= '0;
            rob_out_q <= '0;
            rd_out_q  <= '0;
`ifdef BRANCH_RS_OLDEST_FIRST_EN
            for (int i = 0; i < RS_ENTRIES; i++) age_q[i] <= '0;
`endif
        end else begin
            valid_q   <= valid_d;
            s1_rdy_q  <= s1_rdy_d;
            s2_rdy_q  <= s2_rdy_d;
            op_q      <= op_d;
            pc_q      <= pc_d;
            s1_val_q  <= s1_val_d;
            s2_val_q  <= s2_val_d;
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
            rob_q     <= rob_d;
            rd_q      <= rd_d;
`ifdef BRANCH_RS_OLDEST_FIRST_EN
            age_q     <= age_d;
`endif
            count_q   <= count_d;
            exe_v_q   <= exe_v_d;
            opcode_q  <= opcode_d;
            pc_out_q  <= pc_out_d;
            opnd1_q   <= opnd1_d;
            opnd2_q   <= opnd2_d;
            rob_out_q <= rob_out_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign exe_v_o    = exe_v_q;
    assign opcode_o   = opcode_q;
    assign pc_o       = pc_out_q;
    assign operand1_o = opnd1_q;
    assign operand2_o = opnd2_q;
    assign rob_dest_o = rob_out_q;
    assign reg_dest_o = rd_out_q;
    assign count_o    = count_q;
endmodule

// File: tb/tb_branch_rs.sv
// tb/tb_branch_rs.sv - self-checking bench for branch_rs (vector table plus issue scoreboard)
module tb_branch_rs;
    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0;
    logic        disp_v = 1'b0, disp_ready;
    logic [3:0]  d_op = '0;
    logic [15:0] d_pc = '0, d_v1 = '0, d_v2 = '0;
    logic        d_r1 = 1'b0, d_r2 = 1'b0;
    logic [4:0]  d_t1 = '0, d_t2 = '0, d_rd = '0;
    logic [3:0]  d_rob = '0;
    logic        cdb_v = 1'b0;
    logic [4:0]  cdb_dest = '0;
    logic [15:0] cdb_res = '0;
    logic        exe_v;
    logic [3:0]  opcode, rob_dest;
    logic [15:0] pc, opnd1, opnd2;
    logic [4:0]  reg_dest;
    logic [2:0]  count;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] pc;
        logic [15:0] o1;
        logic [15:0] o2;
        logic [3:0]  rob;
        logic [4:0]  rd;
    } iss_t;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] pc, v1, v2;
        logic [3:0]  rob;
        logic [4:0]  rd;
        int          exp_cnt;
        bit          exp_exe;
    } vec_t;

    iss_t exp_q[$];
    vec_t vt[5];
    int   n_vec = 0;
    int   n_err = 0;

    branch_rs dut (
        .clk_i(clk), .reset_i(reset), .flush_i(flush),
        .disp_v_i(disp_v), .disp_ready_o(disp_ready),
        .disp_opcode_i(d_op), .disp_pc_i(d_pc),
        .disp_src1_rdy_i(d_r1), .disp_src2_rdy_i(d_r2),
        .disp_src1_tag_i(d_t1), .disp_src2_tag_i(d_t2),
        .disp_src1_val_i(d_v1), .disp_src2_val_i(d_v2),
        .disp_rob_dest_i(d_rob), .disp_reg_dest_i(d_rd),
        .cdb_v_i(cdb_v), .cdb_dest_i(cdb_dest), .cdb_result_i(cdb_res),
        .exe_v_o(exe_v), .opcode_o(opcode), .pc_o(pc),
        .operand1_o(opnd1), .operand2_o(opnd2),
        .rob_dest_o(rob_dest), .reg_dest_o(reg_dest), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [15:0] p, input logic [15:0] o1,
                        input logic [15:0] o2, input logic [3:0] rob, input logic [4:0] rd);
        iss_t e;
        e = '{op: op, pc: p, o1: o1, o2: o2, rob: rob, rd: rd};
        exp_q.push_back(e);
    endtask

    task automatic disp(input logic [3:0] op, input logic [15:0] p,
                        input logic r1, input logic [4:0] t1, input logic [15:0] v1,
                        input logic r2, input logic [4:0] t2, input logic [15:0] v2,
                        input logic [3:0] rob, input logic [4:0] rd);
        d_op = op; d_pc = p; d_r1 = r1; d_t1 = t1; d_v1 = v1;
        d_r2 = r2; d_t2 = t2; d_v2 = v2; d_rob = rob; d_rd = rd;
        disp_v = 1'b1;
        tick();
        disp_v = 1'b0;
    endtask

    task automatic wait_empty(input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            tick();
            n++;
        end
        @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // scoreboard: every issue must match the head of the expected queue
    always @(negedge clk) begin
        if (exe_v) begin
            iss_t got;
            got = '{op: opcode, pc: pc, o1: opnd1, o2: opnd2, rob: rob_dest, rd: reg_dest};
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 64'(got), 64'd0);
            end else begin
                chk("issue_bundle", 64'(got), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            vt[i] = '{op: 4'(i + 1), pc: 16'h0200 + 16'(4 * i), v1: 16'h0A00 + 16'(i),
                      v2: 16'h0B00 + 16'(i), rob: 4'(10 + i), rd: 5'(16 + i),
                      exp_cnt: 1, exp_exe: (i > 0)};
        end

        // reset
        repeat (2) tick();
        @(negedge clk);
        chk("rst_exe_v", 64'(exe_v), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(disp_ready), 64'd1);
        chk("rst_pc", 64'(pc), 64'd0);
        reset = 1'b0;
        tick();

        // single ready BCC: visible two cycles after dispatch
        push(4'h1, 16'h0010, 16'h0001, 16'h0005, 4'd3, 5'd2);
        disp(4'h1, 16'h0010, 1'b1, 5'd0, 16'h0001, 1'b1, 5'd0, 16'h0005, 4'd3, 5'd2);
        @(negedge clk);
        chk("t1_exe_early", 64'(exe_v), 64'd0);
        chk("t1_count1", 64'(count), 64'd1);
        tick();
        @(negedge clk);
        chk("t1_exe_v", 64'(exe_v), 64'd1);
        chk("t1_count0", 64'(count), 64'd0);
        wait_empty(10);

        // table: back-to-back ready dispatches issue in order, count steady
        for (int i = 0; i < 5; i++) begin
            push(vt[i].op, vt[i].pc, vt[i].v1, vt[i].v2, vt[i].rob, vt[i].rd);
            disp(vt[i].op, vt[i].pc, 1'b1, 5'd0, vt[i].v1, 1'b1, 5'd0, vt[i].v2, vt[i].rob, vt[i].rd);
            @(negedge clk);
            chk("tbl_count", 64'(count), 64'(vt[i].exp_cnt));
            chk("tbl_exe_v", 64'(exe_v), 64'(vt[i].exp_exe));
        end
        wait_empty(10);

        // src2 waits on tag 7; tag 6 must not wake it
        push(4'h2, 16'h0020, 16'h0011, 16'hBEEF, 4'd4, 5'd8);
        disp(4'h2, 16'h0020, 1'b1, 5'd0, 16'h0011, 1'b0, 5'd7, 16'h0000, 4'd4, 5'd8);
        cdb_v = 1'b1; cdb_dest = 5'd6; cdb_res = 16'hDEAD;
        @(negedge clk); chk("t2_exe_c1", 64'(exe_v), 64'd0);
        tick(); cdb_v = 1'b0;
        @(negedge clk); chk("t2_exe_c2", 64'(exe_v), 64'd0);
        tick(); cdb_v = 1'b1; cdb_dest = 5'd7; cdb_res = 16'hBEEF;
        @(negedge clk); chk("t2_exe_c3", 64'(exe_v), 64'd0);
        tick(); cdb_v = 1'b0;
        @(negedge clk); chk("t2_exe_c4", 64'(exe_v), 64'd0);
        tick();
        @(negedge clk); chk("t2_exe_c5", 64'(exe_v), 64'd1);
        wait_empty(10);

        // dispatch and CDB for the same tag in the same cycle
        push(4'h3, 16'h0030, 16'h1234, 16'h0022, 4'd5, 5'd9);
        cdb_v = 1'b1; cdb_dest = 5'd9; cdb_res = 16'h1234;
        disp(4'h3, 16'h0030, 1'b0, 5'd9, 16'h0000, 1'b1, 5'd0, 16'h0022, 4'd5, 5'd9);
        cdb_v = 1'b0;
        @(negedge clk); chk("t3_exe_c1", 64'(exe_v), 64'd0);
        tick();
        @(negedge clk); chk("t3_exe_c2", 64'(exe_v), 64'd1);
        wait_empty(10);

        // fill: X1 issues and frees index 1, so X3 (younger) lands below X2
        push(4'h2, 16'h0104, 16'h0001, 16'h0002, 4'd6, 5'd11);
        disp(4'h1, 16'h0100, 1'b0, 5'd20, 16'h0000, 1'b1, 5'd0, 16'h000A, 4'd5, 5'd10);
        disp(4'h2, 16'h0104, 1'b1, 5'd0, 16'h0001, 1'b1, 5'd0, 16'h0002, 4'd6, 5'd11);
        disp(4'h1, 16'h0108, 1'b0, 5'd5, 16'h0000, 1'b1, 5'd0, 16'h0003, 4'd7, 5'd12);
        disp(4'h3, 16'h010C, 1'b0, 5'd5, 16'h0000, 1'b1, 5'd0, 16'h0004, 4'd8, 5'd13);
        disp(4'h1, 16'h0110, 1'b1, 5'd0, 16'h0006, 1'b0, 5'd21, 16'h0000, 4'd9, 5'd14);
        @(negedge clk);
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(disp_ready), 64'd0);
        disp(4'h7, 16'h01FF, 1'b1, 5'd0, 16'h0007, 1'b1, 5'd0, 16'h0007, 4'd15, 5'd31);
        @(negedge clk);
        chk("drop_count", 64'(count), 64'd4);
`ifdef BRANCH_RS_OLDEST_FIRST_EN
        push(4'h1, 16'h0108, 16'h5555, 16'h0003, 4'd7, 5'd12);
        push(4'h3, 16'h010C, 16'h5555, 16'h0004, 4'd8, 5'd13);
`else
        push(4'h3, 16'h010C, 16'h5555, 16'h0004, 4'd8, 5'd13);
        push(4'h1, 16'h0108, 16'h5555, 16'h0003, 4'd7, 5'd12);
`endif
        cdb_v = 1'b1; cdb_dest = 5'd5; cdb_res = 16'h5555;
        tick();
        cdb_v = 1'b0;
        wait_empty(10);
        chk("wake_count", 64'(count), 64'd2);
        push(4'h1, 16'h0100, 16'h2020, 16'h000A, 4'd5, 5'd10);
        push(4'h1, 16'h0110, 16'h0006, 16'h2121, 4'd9, 5'd14);
        cdb_v = 1'b1; cdb_dest = 5'd20; cdb_res = 16'h2020;
        tick();
        cdb_dest = 5'd21; cdb_res = 16'h2121;
        tick();
        cdb_v = 1'b0;
        wait_empty(10);
        chk("empty_count", 64'(count), 64'd0);

        // flush with two ready entries and a concurrent dispatch
        disp(4'h4, 16'h0300, 1'b0, 5'd11, 16'h0000, 1'b1, 5'd0, 16'h0001, 4'd1, 5'd1);
        disp(4'h4, 16'h0304, 1'b0, 5'd11, 16'h0000, 1'b1, 5'd0, 16'h0002, 4'd2, 5'd2);
        cdb_v = 1'b1; cdb_dest = 5'd11; cdb_res = 16'h1111;
        tick();
        cdb_v = 1'b0;
        flush = 1'b1;
        disp(4'h4, 16'h0308, 1'b1, 5'd0, 16'h0003, 1'b1, 5'd0, 16'h0003, 4'd3, 5'd3);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_exe_v", 64'(exe_v), 64'd0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_ready", 64'(disp_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            chk("post_flush_exe", 64'(exe_v), 64'd0);
        end

        // reset in the middle of an issue zeroes the held bundle
        disp(4'h5, 16'h0400, 1'b1, 5'd0, 16'h0044, 1'b1, 5'd0, 16'h0045, 4'd6, 5'd6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_exe_v", 64'(exe_v), 64'd0);
        chk("rst2_bundle", 64'({opcode, pc, opnd1, opnd2, rob_dest, reg_dest}), 64'd0);
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_ready", 64'(disp_ready), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("final_queue", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/branch_rs.md
Name: branch_rs

Overview:
Branch reservation station. It is the issue side of the branch functional unit's execute interface. It accepts dispatched branch micro-ops (BCC/BL/others) with operand readiness tags and snoops the CDB to wake waiting operands. It issues one ready entry per cycle as a registered exe_v/opcode/pc/operand/rob_dest/reg_dest bundle that drives the branch FU inputs directly.

Parameters:
RS_ENTRIES, 4, number of station entries (power of 2, >=2)
WORD_SIZE_P, 16, data/PC width
WIDTH_OP, 4, opcode width
ROB_ENTRY, 16, ROB depth; rob tag width = $clog2(ROB_ENTRY)
NUM_PHYS_REG, 32, physical regs; tag width = $clog2(NUM_PHYS_REG)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
flush_i  in  1  mispredict/pipeline flush; kills all entries
disp_v_i  in  1  dispatch valid
disp_ready_o  out  1  free entry exists
disp_opcode_i  in  WIDTH_OP  opcode
disp_pc_i  in  WORD_SIZE_P  instruction PC
disp_src1_rdy_i / disp_src2_rdy_i  in  1 each  operand value already valid
disp_src1_tag_i / disp_src2_tag_i  in  $clog2(NUM_PHYS_REG) each  producer phys reg when not ready
disp_src1_val_i / disp_src2_val_i  in  WORD_SIZE_P each  operand value when ready
disp_rob_dest_i  in  $clog2(ROB_ENTRY)  ROB slot
disp_reg_dest_i  in  $clog2(NUM_PHYS_REG)  dest phys reg (BL link)
cdb_v_i  in  1  CDB broadcast valid
cdb_dest_i  in  $clog2(NUM_PHYS_REG)  broadcast tag
cdb_result_i  in  WORD_SIZE_P  broadcast value
exe_v_o  out  1  issue valid to branch FU
opcode_o  out  WIDTH_OP
pc_o  out  WORD_SIZE_P
operand1_o / operand2_o  out  WORD_SIZE_P each
rob_dest_o  out  $clog2(ROB_ENTRY)
reg_dest_o  out  $clog2(NUM_PHYS_REG)
count_o  out  $clog2(RS_ENTRIES)+1  occupied entries

Behaviour:
- Reset: all entries invalid; all outputs 0; count_o=0; disp_ready_o=1.
- disp_ready_o = (count_o < RS_ENTRIES). It is combinational from registered occupancy and ignores any same-cycle issue. Dispatch when disp_v_i && !disp_ready_o is dropped. The upstream stage must hold the op.
- Dispatch writes the lowest-index free entry at the clock edge. The new entry becomes issue-eligible the following cycle.
- Wake-up: each cycle, every valid entry whose operand is not ready and whose tag == cdb_dest_i while cdb_v_i is set captures cdb_result_i and marks the operand ready.
- Dispatch/CDB same cycle: if a dispatched operand is not ready and its tag matches the CDB, the value is captured at dispatch (the entry is written ready). No broadcast may be missed.
- Issue select: among valid entries with both operands ready, pick the oldest (dispatch order via age matrix). The pick is combinational in cycle N. The entry is freed and the output bundle registered at the end of cycle N, so exe_v_o is visible in cycle N+1. At most one issue per cycle. exe_v_o=0 (other outputs hold) when nothing is ready.
- An entry made ready by the CDB in cycle N is selectable in cycle N+1 (no CDB-to-issue same-cycle bypass).
- count_o next = count + dispatch_accepted - issued. Simultaneous dispatch and issue leaves the count unchanged.
- flush_i (synchronous, in cycle N): all entries invalid, count 0, exe_v_o=0 in N+1. Dispatch and issue in cycle N are discarded. Flush wins over everything except reset.
- Reset mid-operation: identical to flush plus all outputs zeroed.
- No fairness state beyond age, and no replay.

Optional Feature:
BRANCH_RS_OLDEST_FIRST_EN
- Defined: age-matrix oldest-ready select as above.
- Undefined: the age matrix is removed and the lowest-index ready entry is issued (fixed priority). All other timing is identical.

Test Plan:
- Reset, then dispatch BCC pc=0x0010 with both operands ready (op2=0x0005, rob=3) -> exe_v_o=1 two cycles after dispatch cycle, pc_o=0x0010, operand2_o=0x0005, rob_dest_o=3; count_o returns to 0.
- Dispatch with src2 waiting on tag 7. CDB tag 7 value 0xBEEF arrives 3 cycles later -> issue the cycle after wake-up with operand2_o=0xBEEF. A CDB with tag 6 causes no wake.
- Dispatch with src1 tag 9 not ready while CDB broadcasts tag 9 =0x1234 in the same cycle -> entry issues next cycle with operand1_o=0x1234.
- Fill 4 entries, none ready -> disp_ready_o=0, count_o=4, and a 5th dispatch is dropped. Wake entries 3 then 1 in one CDB (shared tag) -> with the macro, the older one issues first; without it, index 1 issues first.
- Two entries ready plus a dispatch and flush_i in the same cycle -> next cycle exe_v_o=0, count_o=0, disp_ready_o=1, and nothing issues afterwards.
- Back-to-back: 3 ready entries -> exe_v_o high 3 consecutive cycles in dispatch order, while a concurrent dispatch keeps count_o stable.
